reg_file_sb: RTL
================

# reg_file_sb

Parametrised register file with a write-back scoreboard. It is the successor to the fixed 8×8 register memory in the MIPS_Lite datapath, adding:
- configurable data width and register count;
- an optional hardwired-zero register;
- optional same-cycle write-to-read bypass;
- per-register pending bits for multi-cycle operations such as MULT, with a hazard output the control unit uses to stall issue.

It sits between decode, which supplies rs/rt/rd, and the ALU/write-back stage.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, register address width; the file holds NREG = 2**ADDR_W registers
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes and issues
- BYPASS, 1, when 1, write-back data forwards combinationally to the read ports in the same cycle

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- rs_in  in  ADDR_W  read address A
- rt_in  in  ADDR_W  read address B
- rd_in  in  ADDR_W  read address for store data
- rs_out  out  DATA_W  contents of rs_in
- rt_out  out  DATA_W  contents of rt_in
- save_out  out  DATA_W  contents of rd_in
- issue_valid  in  1  a multi-cycle op targeting issue_rd is launched this cycle
- issue_rd  in  ADDR_W  destination of the launched op
- reg_write  in  1  write-back strobe
- wb_rd  in  ADDR_W  write-back destination
- from_reg_src  in  DATA_W  write-back data
- hazard  out  1  a source operand (rs_in, rt_in or rd_in) is pending
- busy_mask  out  NREG  pending bit per register
- waw_err  out  1  sticky flag: an issue targeted a register that was already pending
- wb_count  out  16  number of accepted write-backs, saturating at 16'hFFFF

## Operation
- **Reset.** While rst is high, all registers, busy_mask, waw_err and wb_count are 0. As a result, rs_out, rt_out and save_out read 0 and hazard is 0.
- **Write.** When reg_write=1 and wb_rd is not suppressed, regs[wb_rd] ← from_reg_src at the clock edge. A register is suppressed only when wb_rd=0 and ZERO_REG=1; a suppressed write does not change wb_count.
- **wb_count.** Increments by 1 for each accepted write and holds at 16'hFFFF once reached.
- **Reads.** All three read ports are combinational from the register array.
  - With BYPASS=1: if reg_write=1 and wb_rd equals the read address (and wb_rd is not suppressed), the port outputs from_reg_src.
  - Register 0 with ZERO_REG=1 always reads 0, regardless of bypass.
- **Scoreboard, per register r:**
  - set busy[r] when issue_valid=1 and issue_rd=r;
  - clear busy[r] when an accepted write-back has wb_rd=r;
  - if both happen in the same cycle, set wins: the newer op remains outstanding;
  - r=0 with ZERO_REG=1 is never set busy.
- **waw_err.** Set when issue_valid=1 and busy[issue_rd]=1 and that bit is not being cleared in the same cycle. It stays set until reset.
- **Write-back to a non-busy register** is legal (single-cycle ops) and leaves the busy bit at 0.
- **hazard** = OR over the addresses p ∈ {rs_in, rt_in, rd_in} of eff_busy[p], where:
  - eff_busy[p] = busy[p] AND NOT (BYPASS AND reg_write AND wb_rd==p);
  - with BYPASS=0, a register being written back this cycle still counts as busy.
- **Reset mid-operation.** Reset discards all pending bits. Any write-back that arrives afterwards is an ordinary write.

## Timing
- Write latency: 1 cycle to the array.
  - BYPASS=1: the value is visible on read ports in the same cycle.
  - BYPASS=0: the value is visible in the cycle after the edge.
- Issue → busy_mask bit high after the next rising edge. hazard reflects it from that cycle onward.
- Write-back → busy bit low after the edge. With BYPASS=1, hazard drops in the write-back cycle itself.
- waw_err and wb_count update at the edge following the triggering cycle.
- hazard is purely combinational from the read addresses, busy_mask and the write-back inputs. There is no path from issue_valid to hazard.

## Structure
- The shared package mips_lite_pkg holds the default DATA_W/ADDR_W constants and the REG_ZERO address constant.
- One sub-module, reg_sb_scoreboard, holds busy_mask, the waw_err logic and the eff_busy/hazard logic. It is parametrised by ADDR_W, ZERO_REG and BYPASS.
- The top level holds the register array, the read muxes with bypass, and wb_count.

## Test plan
- **Reset.** Pulse rst asynchronously mid-cycle → all outputs 0, including busy_mask=8'h00 and wb_count=0.
- **Write/read.** Write 5 to r1 and 4 to r2 → rs_in=1, rt_in=2 gives rs_out=5, rt_out=4.
- **Bypass.** In the same cycle as reg_write r3=20, set rs_in=3.
  - BYPASS=1: rs_out=20 immediately.
  - BYPASS=0: rs_out=0 in that cycle, then 20 in the next.
- **Zero register.** With ZERO_REG=1, write 8'hAA to r0 → rs_out=0 for rs_in=0, wb_count unchanged. With ZERO_REG=0, rs_out=8'hAA.
- **MULT stall.** Issue to r3, then hold rs_in=3 → busy_mask=8'h08 and hazard=1 for 4 cycles. Write back 20 to r3 → hazard=0 in that cycle (BYPASS=1), rs_out=20, busy_mask=0.
- **Simultaneous and WAW.**
  - Issue r5 and write back r5 in the same cycle → busy[5]=1 afterwards, waw_err=0.
  - A second issue to r5 while busy → waw_err=1, which persists until rst.

Source files
------------

// File: rtl/mips_lite_pkg.sv
// mips_lite_pkg: shared register-file defaults and the hardwired-zero address
package mips_lite_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/reg_sb_scoreboard.sv
// reg_sb_scoreboard: per-register pending bits, sticky WAW flag and operand hazard
module reg_sb_scoreboard
  import mips_lite_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic                 reg_write,
  input  logic [ADDR_W-1:0]    wb_rd,
  input  logic [ADDR_W-1:0]    rs_in,
  input  logic [ADDR_W-1:0]    rt_in,
  input  logic [ADDR_W-1:0]    rd_in,
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic                 waw_err,
  output logic                 hazard
);
  localparam int NREG = 2**ADDR_W;
  logic [NREG-1:0] r_busy;
  logic            r_waw;
  logic            w_wb_acc;
  logic            w_iss_ok;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_eff;
  // decode set/clear vectors; a bypassed write-back hides its register from the hazard
  always_comb begin
    w_wb_acc = reg_write && !((ZERO_REG != 0) && (wb_rd == ADDR_W'(REG_ZERO)));
    w_iss_ok = issue_valid && !((ZERO_REG != 0) && (issue_rd == ADDR_W'(REG_ZERO)));
    w_clr = w_wb_acc ? (NREG'(1) << wb_rd) : '0;
    w_set = w_iss_ok ? (NREG'(1) << issue_rd) : '0;
    w_eff = r_busy & ~((BYPASS != 0) ? w_clr : '0);
    hazard = w_eff[rs_in] | w_eff[rt_in] | w_eff[rd_in];
  end
  // set beats clear so a re-issue in the write-back cycle stays outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_waw <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (issue_valid && r_busy[issue_rd] && !w_clr[issue_rd]) r_waw <= 1'b1;
    end
  end
  assign busy_mask = r_busy;
  assign waw_err = r_waw;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with bypass, write-back counter and scoreboard
module reg_file_sb
  import mips_lite_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    rs_in,
  input  logic [ADDR_W-1:0]    rt_in,
  input  logic [ADDR_W-1:0]    rd_in,
  output logic [DATA_W-1:0]    rs_out,
  output logic [DATA_W-1:0]    rt_out,
  output logic [DATA_W-1:0]    save_out,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic                 reg_write,
  input  logic [ADDR_W-1:0]    wb_rd,
  input  logic [DATA_W-1:0]    from_reg_src,
  output logic                 hazard,
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic                 waw_err,
  output logic [15:0]          wb_count
);
  localparam int NREG = 2**ADDR_W;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [15:0]       r_wb_count;
  logic              w_wb_acc;
  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    return ((ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO))) ? '0 :
           ((BYPASS != 0) && w_wb_acc && (wb_rd == a)) ? from_reg_src : r_regs[a];
  endfunction
  // three combinational read ports with optional same-cycle forwarding
  always_comb begin
    w_wb_acc = reg_write && !((ZERO_REG != 0) && (wb_rd == ADDR_W'(REG_ZERO)));
    rs_out = rd_port(rs_in);
    rt_out = rd_port(rt_in);
    save_out = rd_port(rd_in);
  end
  // register array write and saturating accepted-write counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_wb_count <= '0;
    end else begin
      if (w_wb_acc) r_regs[wb_rd] <= from_reg_src;
      if (w_wb_acc && r_wb_count != 16'hFFFF) r_wb_count <= r_wb_count + 16'd1;
    end
  end
  assign wb_count = r_wb_count;
  reg_sb_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_sb (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .reg_write(reg_write),
    .wb_rd(wb_rd),
    .rs_in(rs_in),
    .rt_in(rt_in),
    .rd_in(rd_in),
    .busy_mask(busy_mask),
    .waw_err(waw_err),
    .hazard(hazard)
  );
endmodule
